// File: rtl/singen_fx_pkg.sv
//==============================================================================
// Module : singen_fx_pkg
// Purpose: Shared constants and helpers for the sine-to-effects demo block:
//          sample width, midscale, sine ROM lookup, saturation and
//          offset-binary <-> two's-complement conversion.
// Ports  : none (package)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package singen_fx_pkg;

  localparam int SW = 12;
  localparam logic [SW-1:0] MIDSCALE = 12'd2048;
  localparam int ROM_DEPTH = 64;
  localparam int IW = $clog2(ROM_DEPTH);

  // Offset binary <-> two's complement is just an MSB flip in both directions.
  function automatic logic [SW-1:0] to_signed(input logic [SW-1:0] x);
    return {~x[SW-1], x[SW-2:0]};
  endfunction

  function automatic logic [SW-1:0] to_offset(input logic [SW-1:0] x);
    return {~x[SW-1], x[SW-2:0]};
  endfunction

  // Clamp a 14-bit signed sum into the 12-bit signed range.
  function automatic logic [SW-1:0] sat12(input logic signed [SW+1:0] v);
    if (v > 14'sd2047)
      return 12'h7FF;
    else if (v < -14'sd2048)
      return 12'h800;
    else
      return v[SW-1:0];
  endfunction

  // round(2048 + 2047*sin(2*pi*k/64)) built from a quarter-wave table.
  function automatic logic [SW-1:0] sine_rom(input logic [IW-1:0] k);
    logic [4:0]  j;
    logic [10:0] a;
    // Odd quadrants run the quarter table backwards (index 16 down to 1).
    j = k[4] ? 5'(5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
    case (j)
      5'd0:    a = 11'd0;
      5'd1:    a = 11'd201;
      5'd2:    a = 11'd399;
      5'd3:    a = 11'd594;
      5'd4:    a = 11'd783;
      5'd5:    a = 11'd965;
      5'd6:    a = 11'd1137;
      5'd7:    a = 11'd1299;
      5'd8:    a = 11'd1447;
      5'd9:    a = 11'd1582;
      5'd10:   a = 11'd1702;
      5'd11:   a = 11'd1805;
      5'd12:   a = 11'd1891;
      5'd13:   a = 11'd1959;
      5'd14:   a = 11'd2008;
      5'd15:   a = 11'd2037;
      5'd16:   a = 11'd2047;
      default: a = 11'd0;
    endcase
    // Second half-period is the negative lobe.
    return k[5] ? 12'(MIDSCALE - {1'b0, a}) : 12'(MIDSCALE + {1'b0, a});
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx_delay_line.sv
//==============================================================================
// Module : fx_delay_line
// Purpose: Circular sample buffer with write pointer, saturating fill counter
//          and NTAP fixed-lag read taps. A tap whose lag exceeds the number of
//          samples written since reset reads as 0, so stale RAM never leaks.
// Ports  : clk, rst      clock / async active-high reset
//          i_we          write strobe (one per sample)
//          i_din  [11:0] two's-complement sample to store
//          o_taps [NTAP] tap t = sample written LAG_t writes ago (or 0)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module fx_delay_line
  import singen_fx_pkg::*;
#(
  parameter int                  DEPTH = 256,
  parameter int                  NTAP  = 1,
  parameter logic [NTAP*16-1:0]  LAGS  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [SW-1:0]              i_din,
  output logic [NTAP-1:0][SW-1:0]    o_taps
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [SW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [FW-1:0] r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (i_we) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_fill != FW'(DEPTH))
        r_fill <= r_fill + 1'b1;
    end
  end

  // RAM contents are deliberately not reset; the fill counter guards reads.
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[r_wptr] <= i_din;
  end

  // Taps are read before the current sample is written, so a lag of L
  // returns the sample from L writes ago, valid once L samples exist.
  for (genvar t = 0; t < NTAP; t++) begin : g_tap
    localparam logic [15:0] LAG = LAGS[t*16 +: 16];
    logic [AW-1:0] w_addr;
    logic          w_valid;
    assign w_addr    = r_wptr - AW'(LAG);
    assign w_valid   = (32'(LAG) <= 32'(r_fill));
    assign o_taps[t] = w_valid ? r_mem[w_addr] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/singen_to_effects.sv
//==============================================================================
// Module : singen_to_effects
// Purpose: Self-running sine generator feeding overdrive, delay, echo and
//          reverb effect paths. All five streams are registered 12-bit
//          offset-binary outputs. The sine output updates once every CLK_DIV
//          clocks; the effect outputs follow exactly one clock later.
// Ports  : clk, rst          clock / async active-high reset
//          bypass            (EFFECTS_BYPASS_EN only) effects mirror the sine
//          data_out_sin      raw sine sample
//          data_out_OD       overdriven sample
//          data_out_DELAY    delayed sample
//          data_out_ECHO     echo sample
//          data_out_REVERB   reverb sample
// Config : define EFFECTS_BYPASS_EN to add the bypass input.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module singen_to_effects
  import singen_fx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int OD_GAIN_SH = 2,
  parameter int OD_CLIP    = 1023,
  parameter int BUF_DEPTH  = 256,
  parameter int DELAY_TAP  = 200,
  parameter int ECHO_TAP   = 128,
  parameter int REV_TAP1   = 37,
  parameter int REV_TAP2   = 89,
  parameter int REV_TAP3   = 151
) (
  input  logic          clk,
  input  logic          rst,
`ifdef EFFECTS_BYPASS_EN
  input  logic          bypass,
`endif
  output logic [SW-1:0] data_out_sin,
  output logic [SW-1:0] data_out_OD,
  output logic [SW-1:0] data_out_DELAY,
  output logic [SW-1:0] data_out_ECHO,
  output logic [SW-1:0] data_out_REVERB
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic signed [14:0] C_CLIP = 15'(OD_CLIP);

  logic [DW-1:0] r_div;
  logic [IW-1:0] r_idx;
  logic          r_upd;
  logic          w_tick;
  logic          w_byp;

`ifdef EFFECTS_BYPASS_EN
  assign w_byp = bypass;
`else
  assign w_byp = 1'b0;
`endif

  assign w_tick = (r_div == DW'(CLK_DIV - 1));

  // Divider, phase index and sine output; r_upd marks the effect-update clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_idx        <= '0;
      r_upd        <= 1'b0;
      data_out_sin <= MIDSCALE;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      r_upd <= w_tick;
      if (w_tick) begin
        data_out_sin <= sine_rom(r_idx);
        r_idx        <= r_idx + 1'b1;
      end
    end
  end

  logic [SW-1:0]         w_s;
  logic [3:0][SW-1:0]    w_dry;
  logic [0:0][SW-1:0]    w_etap;
  logic [SW-1:0]         w_e;
  logic signed [13:0]    w_e_sum;
  logic signed [13:0]    w_rv_sum;
  logic signed [14:0]    w_od_pre;
  logic signed [14:0]    w_od_clip;

  assign w_s = to_signed(data_out_sin);

  // Dry line: tap 0 feeds the delay output, taps 1..3 the reverb.
  fx_delay_line #(
    .DEPTH (BUF_DEPTH),
    .NTAP  (4),
    .LAGS  ({16'(REV_TAP3), 16'(REV_TAP2), 16'(REV_TAP1), 16'(DELAY_TAP)})
  ) u_dry (
    .clk    (clk),
    .rst    (rst),
    .i_we   (r_upd),
    .i_din  (w_s),
    .o_taps (w_dry)
  );

  // Echo line stores the echo output itself (feedback), even in bypass.
  fx_delay_line #(
    .DEPTH (BUF_DEPTH),
    .NTAP  (1),
    .LAGS  (16'(ECHO_TAP))
  ) u_echo (
    .clk    (clk),
    .rst    (rst),
    .i_we   (r_upd),
    .i_din  (w_e),
    .o_taps (w_etap)
  );

  assign w_od_pre = 15'($signed(w_s)) <<< OD_GAIN_SH;

  always_comb begin
    w_od_clip = w_od_pre;
    if (w_od_pre > C_CLIP)
      w_od_clip = C_CLIP;
    else if (w_od_pre < -C_CLIP)
      w_od_clip = -C_CLIP;
  end

  assign w_e_sum  = 14'($signed(w_s)) + (14'($signed(w_etap[0])) >>> 1);
  assign w_e      = sat12(w_e_sum);

  assign w_rv_sum = 14'($signed(w_s))
                  + (14'($signed(w_dry[1])) >>> 1)
                  + (14'($signed(w_dry[2])) >>> 2)
                  + (14'($signed(w_dry[3])) >>> 3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_OD     <= MIDSCALE;
      data_out_DELAY  <= MIDSCALE;
      data_out_ECHO   <= MIDSCALE;
      data_out_REVERB <= MIDSCALE;
    end else if (r_upd) begin
      if (w_byp) begin
        data_out_OD     <= data_out_sin;
        data_out_DELAY  <= data_out_sin;
        data_out_ECHO   <= data_out_sin;
        data_out_REVERB <= data_out_sin;
      end else begin
        data_out_OD     <= to_offset(w_od_clip[SW-1:0]);
        data_out_DELAY  <= to_offset(w_dry[0]);
        data_out_ECHO   <= to_offset(w_e);
        data_out_REVERB <= to_offset(sat12(w_rv_sum));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_singen_to_effects.sv
//==============================================================================
// Module : tb_singen_to_effects
// Purpose: Self-checking bench for singen_to_effects against a sample-indexed
//          history model of the sine source and the four effect equations.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_singen_to_effects;

  localparam int OD_GAIN_SH = 2;
  localparam int OD_CLIP    = 1023;
  localparam int DELAY_TAP  = 200;
  localparam int ECHO_TAP   = 128;
  localparam int T1 = 37, T2 = 89, T3 = 151;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_out_sin, data_out_OD, data_out_DELAY, data_out_ECHO, data_out_REVERB;
`ifdef EFFECTS_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  singen_to_effects dut (
    .clk             (clk),
    .rst             (rst),
`ifdef EFFECTS_BYPASS_EN
    .bypass          (bypass),
`endif
    .data_out_sin    (data_out_sin),
    .data_out_OD     (data_out_OD),
    .data_out_DELAY  (data_out_DELAY),
    .data_out_ECHO   (data_out_ECHO),
    .data_out_REVERB (data_out_REVERB)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int rom [64];
  int s_h [1024];
  int e_h [1024];
  int n_smp;
  bit pend;
  int exp_sin, exp_od, exp_dl, exp_ec, exp_rv;
  int nxt_od, nxt_dl, nxt_ec, nxt_rv;

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int dry_tap(input int n, input int lag);
    return (n >= lag) ? s_h[n - lag] : 0;
  endfunction

  task automatic check(input string tag, input int n, input logic [11:0] obs, input int expv);
    n_assert++;
    assert (obs === 12'(expv)) else begin
      n_fail++;
      $error("FAIL %s sample=%0d observed=%0d expected=%0d", tag, n, obs, expv);
    end
  endtask

  task automatic check_fx(input string tag, input int n);
    check({tag, "_od"}, n, data_out_OD,     exp_od);
    check({tag, "_dly"}, n, data_out_DELAY,  exp_dl);
    check({tag, "_echo"}, n, data_out_ECHO,   exp_ec);
    check({tag, "_rev"}, n, data_out_REVERB, exp_rv);
  endtask

  // Evaluate the effect equations for sample n from the recorded history.
  task automatic model_sample(input int n, input bit byp);
    int s, t, e;
    s = rom[n % 64] - 2048;
    s_h[n] = s;
    t = s * (1 << OD_GAIN_SH);
    if (t > OD_CLIP) t = OD_CLIP;
    if (t < -OD_CLIP) t = -OD_CLIP;
    e = sat(s + ((n >= ECHO_TAP) ? (e_h[n - ECHO_TAP] >>> 1) : 0));
    e_h[n] = e;
    exp_sin = rom[n % 64];
    if (byp) begin
      nxt_od = exp_sin; nxt_dl = exp_sin; nxt_ec = exp_sin; nxt_rv = exp_sin;
    end else begin
      nxt_od = t + 2048;
      nxt_dl = dry_tap(n, DELAY_TAP) + 2048;
      nxt_ec = e + 2048;
      nxt_rv = sat(s + (dry_tap(n, T1) >>> 1) + (dry_tap(n, T2) >>> 2)
                     + (dry_tap(n, T3) >>> 3)) + 2048;
    end
  endtask

  task automatic do_reset(input int cyc);
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    exp_sin = 2048; exp_od = 2048; exp_dl = 2048; exp_ec = 2048; exp_rv = 2048;
    check("rst_sin", -1, data_out_sin, exp_sin);
    check_fx("rst", -1);
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    n_smp = 0;
    pend  = 1'b0;
  endtask

  // Each iteration spans 16 clocks starting from divider count 0.
  task automatic run(input int cnt);
    bit byp;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      if (pend) begin
        exp_od = nxt_od; exp_dl = nxt_dl; exp_ec = nxt_ec; exp_rv = nxt_rv;
        check_fx("upd", n_smp - 1);
        pend = 1'b0;
      end
      repeat (14) @(posedge clk);
      #1;
      check("hold_sin", n_smp, data_out_sin, exp_sin);
      check_fx("hold", n_smp);
      byp = 1'b0;
`ifdef EFFECTS_BYPASS_EN
      byp = ($urandom_range(0, 3) == 0);
      bypass = byp;
`endif
      model_sample(n_smp, byp);
      @(posedge clk); #1;
      check("sin", n_smp, data_out_sin, exp_sin);
      check_fx("lag", n_smp);
      pend = 1'b1;
      n_smp++;
    end
  endtask

  task automatic flush();
    @(posedge clk); #1;
    if (pend) begin
      exp_od = nxt_od; exp_dl = nxt_dl; exp_ec = nxt_ec; exp_rv = nxt_rv;
      check_fx("upd", n_smp - 1);
      pend = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      rom[k] = $rtoi(2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0) + 0.5);
    rst  = 1'b0;
    pend = 1'b0;
    #2;
    do_reset(3);
    // Long run: full sine periods, delay/echo/reverb fill boundaries.
    run(300);
    flush();
    // Random-length reset, then stop at k=20 for the mid-stream reset.
    do_reset($urandom_range(2, 5));
    run(21);
    flush();
    do_reset(3);
    // After reset the taps must read zero again despite stale RAM.
    run(210);
    flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
